// File: rtl/signed_bcd_converter_pkg.sv
// Shared types and constants for the signed BCD conversion stage.
package signed_bcd_converter_pkg;

  // Width of the MDR result value feeding the display path.
  localparam int unsigned IVW = 8;

  // Bits per packed BCD digit.
  localparam int unsigned BCD_W = 4;

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_e;

  // Counter width able to hold the value w (the number of shift steps).
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/signed_bcd_converter_bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: adds 3 when the digit is >= 5,
// so the following left shift carries correctly into the next digit.
module bcd_add3_digit
  import signed_bcd_converter_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  output logic [BCD_W-1:0] o_digit
);

  // Conditional +3 correction.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd5) begin
      o_digit = i_digit + 4'd3;
    end
  end

endmodule

// File: rtl/signed_bcd_converter.sv
// Sequential sign/magnitude split followed by a bit-serial double-dabble
// binary-to-BCD conversion, with a start/ready/valid handshake.
module signed_bcd_converter
  import signed_bcd_converter_pkg::*;
#(
  parameter int unsigned W           = IVW,
  parameter int unsigned DIGITS      = 3,
  parameter bit          SIGNED_MODE = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [W-1:0]              i_val,
  output logic                      o_ready,
  output logic                      o_valid,
  output logic [BCD_W*DIGITS-1:0]   o_bcd,
  output logic                      o_sign,
  output logic                      o_ovf
);

  localparam int unsigned BW = BCD_W * DIGITS;
  localparam int unsigned CW = cnt_width(W);

  bcd_state_e      r_state;
  logic [W-1:0]    r_mag;
  logic [BW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_sign;
  logic            r_ovf;

  logic            w_neg;
  logic [W-1:0]    w_mag;
  logic [BW-1:0]   w_adj;

  // Sign/magnitude front end; the most-negative value maps to 2^(W-1),
  // which still fits in W unsigned bits.
  assign w_neg = SIGNED_MODE && i_val[W-1];
  assign w_mag = w_neg ? ((~i_val) + {{(W-1){1'b0}}, 1'b1}) : i_val;

  // One add-3 corrector per accumulator digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .i_digit (r_acc[g*BCD_W +: BCD_W]),
      .o_digit (w_adj[g*BCD_W +: BCD_W])
    );
  end

  // Conversion sequencer with registered handshake and result outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_mag   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b1;
      r_ovf   <= 1'b0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_bcd   <= '0;
      o_sign  <= 1'b1;
      o_ovf   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_mag   <= w_mag;
            r_sign  <= ~w_neg;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= CW'(W);
            o_ready <= 1'b0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          // A set bit leaving the top digit means the magnitude needs more
          // digits than we have; the low digits stay correct mod 10^DIGITS.
          r_acc <= {w_adj[BW-2:0], r_mag[W-1]};
          r_mag <= {r_mag[W-2:0], 1'b0};
          if (w_adj[BW-1]) begin
            r_ovf <= 1'b1;
          end
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          o_bcd   <= r_acc;
          o_sign  <= r_sign;
          o_ovf   <= r_ovf;
          o_valid <= 1'b1;
          o_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_bcd_converter.sv
// Self-checking bench for signed_bcd_converter: three instances cover
// signed/3-digit, unsigned/3-digit and signed/2-digit builds.
module tb_signed_bcd_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st  [3];
  logic [7:0]  v   [3];
  logic        rdy [3];
  logic        vld [3];
  logic        sgn [3];
  logic        ov  [3];
  logic [11:0] bcd [3];
  logic [11:0] bcd0;
  logic [11:0] bcd1;
  logic [7:0]  bcd2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign bcd[0] = bcd0;
  assign bcd[1] = bcd1;
  assign bcd[2] = {4'h0, bcd2};

  signed_bcd_converter #(.W(8), .DIGITS(3), .SIGNED_MODE(1'b1)) u_s3 (
    .i_clk(clk), .i_rst(rst), .i_start(st[0]), .i_val(v[0]),
    .o_ready(rdy[0]), .o_valid(vld[0]), .o_bcd(bcd0), .o_sign(sgn[0]), .o_ovf(ov[0])
  );

  signed_bcd_converter #(.W(8), .DIGITS(3), .SIGNED_MODE(1'b0)) u_u3 (
    .i_clk(clk), .i_rst(rst), .i_start(st[1]), .i_val(v[1]),
    .o_ready(rdy[1]), .o_valid(vld[1]), .o_bcd(bcd1), .o_sign(sgn[1]), .o_ovf(ov[1])
  );

  signed_bcd_converter #(.W(8), .DIGITS(2), .SIGNED_MODE(1'b1)) u_s2 (
    .i_clk(clk), .i_rst(rst), .i_start(st[2]), .i_val(v[2]),
    .o_ready(rdy[2]), .o_valid(vld[2]), .o_bcd(bcd2), .o_sign(sgn[2]), .o_ovf(ov[2])
  );

  typedef struct {
    int          d;
    logic [7:0]  val;
    logic [11:0] bcd;
    logic        sign;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the decimal value.
  function automatic void model(input int d, input logic [7:0] val,
                                output logic [11:0] b, output logic s, output logic o);
    bit sg;
    int m;
    int lim;
    sg  = (d != 1);
    m   = (sg && val[7]) ? 256 - int'(val) : int'(val);
    lim = (d == 2) ? 100 : 1000;
    s   = !(sg && val[7]);
    o   = (m >= lim);
    m   = m % lim;
    b   = 12'(((m / 100) % 10) * 256 + ((m / 10) % 10) * 16 + (m % 10));
  endfunction

  // Accept one value on instance d, then wait (bounded) for o_valid.
  task automatic convert(input int d, input logic [7:0] val,
                         output logic [11:0] b, output logic s, output logic o,
                         output int lat, output logic rdy_at_v);
    b = '0; s = 1'b0; o = 1'b0; rdy_at_v = 1'b0; lat = -1;
    @(negedge clk);
    chk("ready_before_start", 32'(rdy[d]), 32'd1);
    st[d] = 1'b1;
    v[d]  = val;
    @(posedge clk);
    #1;
    st[d] = 1'b0;
    v[d]  = 8'($urandom);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (vld[d]) begin
        lat = n; b = bcd[d]; s = sgn[d]; o = ov[d]; rdy_at_v = rdy[d];
        break;
      end
    end
  endtask

  vec_t        tbl [11];
  logic [11:0] gb, eb;
  logic        gs, go, es, eo, gr;
  int          lat;
  int          nv;
  logic [11:0] got;
  logic        rdy_low_ok;

  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      v[i]  = '0;
    end

    tbl[0]  = '{0, 8'h7F, 12'h127, 1'b1, 1'b0};
    tbl[1]  = '{0, 8'h80, 12'h128, 1'b0, 1'b0};
    tbl[2]  = '{0, 8'hFF, 12'h001, 1'b0, 1'b0};
    tbl[3]  = '{0, 8'h00, 12'h000, 1'b1, 1'b0};
    tbl[4]  = '{1, 8'hFF, 12'h255, 1'b1, 1'b0};
    tbl[5]  = '{2, 8'h7F, 12'h027, 1'b1, 1'b1};
    tbl[6]  = '{2, 8'h05, 12'h005, 1'b1, 1'b0};
    tbl[7]  = '{0, 8'hF6, 12'h010, 1'b0, 1'b0};
    tbl[8]  = '{1, 8'h80, 12'h128, 1'b1, 1'b0};
    tbl[9]  = '{2, 8'h9C, 12'h000, 1'b0, 1'b1};
    tbl[10] = '{2, 8'h63, 12'h099, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_ready", 32'(rdy[i]), 32'd1);
      chk("reset_valid", 32'(vld[i]), 32'd0);
      chk("reset_bcd",   32'(bcd[i]), 32'd0);
      chk("reset_sign",  32'(sgn[i]), 32'd1);
      chk("reset_ovf",   32'(ov[i]),  32'd0);
    end
    rst = 1'b0;

    // Directed vectors.
    foreach (tbl[k]) begin
      convert(tbl[k].d, tbl[k].val, gb, gs, go, lat, gr);
      chk("vec_latency", 32'(lat),  32'd10);
      chk("vec_bcd",     32'(gb),   32'(tbl[k].bcd));
      chk("vec_sign",    32'(gs),   32'(tbl[k].sign));
      chk("vec_ovf",     32'(go),   32'(tbl[k].ovf));
      chk("vec_ready_with_valid", 32'(gr), 32'd1);
    end

    // Start pulsed while busy must be ignored.
    @(negedge clk);
    st[0] = 1'b1; v[0] = 8'h03;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    nv = 0; got = '0; rdy_low_ok = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n == 3) begin st[0] = 1'b1; v[0] = 8'h10; end
      if (n == 4) st[0] = 1'b0;
      if (vld[0]) begin nv++; got = bcd[0]; end
      if (n < 10 && rdy[0]) rdy_low_ok = 1'b0;
    end
    chk("busy_valid_count", 32'(nv), 32'd1);
    chk("busy_bcd",         32'(got), 32'h003);
    chk("busy_ready_low",   32'(rdy_low_ok), 32'd1);

    // Reset in the middle of a conversion.
    @(negedge clk);
    st[0] = 1'b1; v[0] = 8'h7F;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(rdy[0]), 32'd1);
    chk("midrst_valid", 32'(vld[0]), 32'd0);
    chk("midrst_bcd",   32'(bcd[0]), 32'd0);
    chk("midrst_sign",  32'(sgn[0]), 32'd1);
    rst = 1'b0;
    nv = 0;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (vld[0]) nv++;
    end
    chk("midrst_no_valid", 32'(nv), 32'd0);
    convert(0, 8'hF6, gb, gs, go, lat, gr);
    chk("postrst_bcd",  32'(gb), 32'h010);
    chk("postrst_sign", 32'(gs), 32'd0);
    chk("postrst_lat",  32'(lat), 32'd10);

    // Randomized values against the arithmetic reference.
    for (int k = 0; k < 60; k++) begin
      int          d;
      logic [7:0]  val;
      d   = int'($urandom_range(0, 2));
      val = 8'($urandom);
      model(d, val, eb, es, eo);
      convert(d, val, gb, gs, go, lat, gr);
      chk("rand_latency", 32'(lat), 32'd10);
      chk("rand_bcd",     32'(gb),  32'(eb));
      chk("rand_sign",    32'(gs),  32'(es));
      chk("rand_ovf",     32'(go),  32'(eo));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
